emu_putchar_buffer: RTL

EMU_PUTCHAR_BUFFER -- requirements
Module: emu_putchar_buffer

---
 rtl/emu_console_pkg.sv | 26 ++
 rtl/emu_sync_fifo.sv | 56 +++++
 rtl/emu_putchar_buffer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/emu_console_pkg.sv
// Shared constants and helpers for the emulator console path.
//   NEWLINE         : byte value counted by the newline tracker
//   DROP_CNT_W      : width of the dropped-byte counter
//   DEFAULT_DEPTH   : default FIFO depth
//   DEFAULT_THRESH  : default fill level that raises irq
//   lvl_op_e        : up/down/hold selector shared by the level and newline counters
//   sat_inc_drop    : saturating increment for the dropped-byte counter
package emu_console_pkg;

  localparam logic [7:0]  NEWLINE        = 8'h0A;
  localparam int unsigned DROP_CNT_W     = 16;
  localparam int unsigned DEFAULT_DEPTH  = 64;
  localparam int unsigned DEFAULT_THRESH = 48;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } lvl_op_e;

  function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
    if (v == '1) return v;
    return v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/emu_sync_fifo.sv
// Byte storage and read/write pointers for the putchar buffer.
// Occupancy is tracked by the parent, which only asserts wr_en/rd_en when legal.
//   clk, rst_n  : clock and asynchronous active-low reset (pointers only)
//   wr_en       : store wr_data at the write pointer
//   rd_en       : advance the read pointer
//   flush       : return both pointers to zero, overriding wr_en/rd_en
//   head_data   : byte at the read pointer (combinational)
module emu_sync_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic       flush,
  output logic [7:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  // DEPTH is a power of two, so the natural pointer rollover is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/emu_putchar_buffer.sv
// Target-to-host console byte buffer with overflow tracking and host interrupt.
//   host_clk / host_rst_n : clock, asynchronous active-low reset
//   run_mode              : target running; bytes accepted only when high
//   putchar_valid/ready/data : target byte handshake
//   rd_en / rd_data / rd_valid : host pop request, popped byte one cycle later
//   flush                 : discard all buffered bytes
//   clr_ovf               : clear ovf and drop_cnt
//   level, ovf, drop_cnt, irq : status to host
module emu_putchar_buffer
  import emu_console_pkg::*;
#(
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned DROP_ON_FULL = 0,
  parameter int unsigned THRESH       = DEFAULT_THRESH
) (
  input  logic                    host_clk,
  input  logic                    host_rst_n,
  input  logic                    run_mode,
  input  logic                    putchar_valid,
  output logic                    putchar_ready,
  input  logic [7:0]              putchar_data,
  input  logic                    rd_en,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  input  logic                    flush,
  input  logic                    clr_ovf,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  output logic [DROP_CNT_W-1:0]   drop_cnt,
  output logic                    irq
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [LW-1:0]         level_q, level_d;
  logic [LW-1:0]         nl_cnt_q, nl_cnt_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  irq_q, irq_d;

  logic       full, empty;
  logic       push, store, drop, pop;
  logic [7:0] head_data;
  lvl_op_e    level_op, nl_op;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  assign putchar_ready = host_rst_n && run_mode && (!full || (DROP_ON_FULL != 0));
  assign push  = putchar_valid && putchar_ready;
  // Flush swallows the incoming byte without counting it as a drop.
  assign store = push && !full && !flush;
  assign drop  = push && full && !flush;
  assign pop   = rd_en && !empty && !flush;

  emu_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (host_clk),
    .rst_n     (host_rst_n),
    .wr_en     (store),
    .wr_data   (putchar_data),
    .rd_en     (pop),
    .flush     (flush),
    .head_data (head_data)
  );

  always_comb begin
    level_op = LVL_HOLD;
    if (store && !pop)      level_op = LVL_INC;
    else if (pop && !store) level_op = LVL_DEC;

    nl_op = LVL_HOLD;
    if ((store && (putchar_data == NEWLINE)) && !(pop && (head_data == NEWLINE)))
      nl_op = LVL_INC;
    else if ((pop && (head_data == NEWLINE)) && !(store && (putchar_data == NEWLINE)))
      nl_op = LVL_DEC;
  end

  always_comb begin
    level_d    = level_q;
    nl_cnt_d   = nl_cnt_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    rd_valid_d = pop;
    rd_data_d  = pop ? head_data : rd_data_q;

    case (level_op)
      LVL_INC: level_d = level_q + LW'(1);
      LVL_DEC: level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (nl_op)
      LVL_INC: nl_cnt_d = nl_cnt_q + LW'(1);
      LVL_DEC: nl_cnt_d = nl_cnt_q - LW'(1);
      default: nl_cnt_d = nl_cnt_q;
    endcase

    if (flush) begin
      level_d  = '0;
      nl_cnt_d = '0;
    end

    // A drop coinciding with the clear is recorded as the first new drop.
    if (clr_ovf) begin
      ovf_d      = drop;
      drop_cnt_d = drop ? {{(DROP_CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = sat_inc_drop(drop_cnt_q);
    end

    // Built from next-state values so irq follows its cause by exactly one cycle.
    irq_d = (nl_cnt_d != '0) || (level_d >= LW'(THRESH)) || ovf_d;
  end

  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      level_q    <= '0;
      nl_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      level_q    <= level_d;
      nl_cnt_q   <= nl_cnt_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= irq_d;
    end
  end

  assign level    = level_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign irq      = irq_q;

endmodule
